// File: rtl/wb_intercon_pipe.sv
// Pipelined Wishbone B4 interconnect: one master to NSLV slaves, BASE/MASK address decode,
// in-order target FIFO of outstanding requests, unmapped-access errors and ack timeout.
module wb_intercon_pipe #(
    parameter int unsigned NSLV    = 5,
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16,
    parameter int unsigned DEPTH   = 4,
    parameter logic [NSLV*AW-1:0] SLV_BASE = {16'h7000, 16'h6000, 16'h5000, 16'h4000, 16'h0000},
    parameter logic [NSLV*AW-1:0] SLV_MASK = {16'hF000, 16'hF000, 16'hFF00, 16'hF000, 16'hC000},
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wbm_cyc,
    input  logic                 wbm_stb,
    input  logic                 wbm_we,
    input  logic [AW-1:0]        wbm_adr,
    input  logic [DW-1:0]        wbm_dat_m,
    output logic [DW-1:0]        wbm_dat_s,
    output logic                 wbm_ack,
    output logic                 wbm_err,
    output logic                 wbm_stall,
    output logic [NSLV-1:0]      wbs_cyc,
    output logic [NSLV-1:0]      wbs_stb,
    output logic                 wbs_we,
    output logic [AW-1:0]        wbs_adr,
    output logic [DW-1:0]        wbs_dat_m,
    input  logic [NSLV*DW-1:0]   wbs_dat_s,
    input  logic [NSLV-1:0]      wbs_ack,
    input  logic [NSLV-1:0]      wbs_stall
);

    localparam int unsigned SW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ABORT} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [SW-1:0]   tgt_q [DEPTH];
    logic [SW-1:0]   tgt_d [DEPTH];
    logic            unm_q [DEPTH];
    logic            unm_d [DEPTH];

    logic            hit_any;
    logic [SW-1:0]   sel_idx;
    logic [NSLV-1:0] sel_oh;
    logic [SW-1:0]   head_tgt, tail_tgt;
    logic            head_unm, tail_unm;
    logic            head_ack, slv_stall_sel;
    logic [DW-1:0]   head_dat;
    logic [NSLV-1:0] holds;
    logic            empty, full, abort, blk, pop, push, flush, timeout_c, stall_int;

    // Address decode: lowest matching slave index wins
    always_comb begin
        hit_any = 1'b0;
        sel_idx = '0;
        sel_oh  = '0;
        for (int i = int'(NSLV) - 1; i >= 0; i--) begin
            if ((wbm_adr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                hit_any = 1'b1;
                sel_idx = SW'(i);
            end
        end
        for (int i = 0; i < int'(NSLV); i++) begin
            sel_oh[i] = hit_any && (sel_idx == SW'(i));
        end
    end

    // FIFO head/tail views and per-slave muxing of the head response
    always_comb begin
        head_tgt      = tgt_q[rd_ptr_q];
        head_unm      = unm_q[rd_ptr_q];
        tail_tgt      = tgt_q[wr_ptr_q - PW'(1)];
        tail_unm      = unm_q[wr_ptr_q - PW'(1)];
        empty         = (count_q == '0);
        full          = (count_q == CW'(DEPTH));
        head_ack      = 1'b0;
        head_dat      = '0;
        holds         = '0;
        slv_stall_sel = 1'b0;
        for (int i = 0; i < int'(NSLV); i++) begin
            if (head_tgt == SW'(i)) begin
                head_ack = wbs_ack[i];
                head_dat = wbs_dat_s[i*DW +: DW];
                holds[i] = !empty && !head_unm;
            end
            if (sel_oh[i]) begin
                slv_stall_sel = wbs_stall[i];
            end
        end
    end

    // Handshake control: blocking, accept, pop, timeout, flush
    always_comb begin
        abort     = (state_q == S_ABORT);
        pop       = !empty && (state_q == S_BUSY) && wbm_cyc && (head_unm || head_ack);
        timeout_c = (TIMEOUT != 0) && !empty && (state_q == S_BUSY) && wbm_cyc && !pop
                    && (tcnt_q == TW'(TIMEOUT - 1));
        // A request accepted in the timeout cycle would be flushed unseen, so hold it off
        blk       = full || (!empty && (tail_unm || !hit_any || (tail_tgt != sel_idx)))
                    || abort || timeout_c;
        stall_int = rst || abort || (wbm_stb && (blk || slv_stall_sel));
        push      = wbm_cyc && wbm_stb && !stall_int;
        flush     = (state_q == S_BUSY) && (!wbm_cyc || timeout_c);
    end

    // FIFO and timeout counter next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        tgt_d    = tgt_q;
        unm_d    = unm_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                tgt_d[wr_ptr_q] = sel_idx;
                unm_d[wr_ptr_q] = !hit_any;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
        if (flush || pop || empty) begin
            tcnt_d = '0;
        end else begin
            tcnt_d = tcnt_q + TW'(1);
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (push) state_d = S_BUSY;
            S_BUSY: begin
                if (!wbm_cyc)            state_d = S_IDLE;
                else if (timeout_c)      state_d = S_ABORT;
                else if (count_d == '0)  state_d = S_IDLE;
            end
            S_ABORT: if (!wbm_cyc) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: responses pass through in the same cycle, everything quiet during reset
    always_comb begin
        wbm_stall = stall_int;
        wbm_ack   = !rst && pop && !head_unm;
        wbm_err   = !rst && ((pop && head_unm) || timeout_c);
        wbm_dat_s = (!rst && !empty && !head_unm) ? head_dat : '0;
        wbs_we    = !rst && wbm_we;
        wbs_adr   = rst ? '0 : wbm_adr;
        wbs_dat_m = rst ? '0 : wbm_dat_m;
        wbs_cyc   = '0;
        wbs_stb   = '0;
        for (int i = 0; i < int'(NSLV); i++) begin
            wbs_cyc[i] = !rst && wbm_cyc && !abort && (sel_oh[i] || holds[i]);
            wbs_stb[i] = !rst && wbm_cyc && wbm_stb && sel_oh[i] && !blk;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tcnt_q   <= tcnt_d;
        end
    end

    // Entry storage is qualified by count_q, so it needs no reset
    always_ff @(posedge clk) begin
        tgt_q <= tgt_d;
        unm_q <= unm_d;
    end

endmodule

// File: tb/tb_wb_intercon_pipe.sv
// Directed self-checking bench for wb_intercon_pipe with latency-programmable slave responders.
module tb_wb_intercon_pipe;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we;
    logic [15:0] adr, dat_m, dat_s;
    logic        ack, err, stall;
    logic [4:0]  s_cyc, s_stb, s_ack, s_stall;
    logic        s_we;
    logic [15:0] s_adr, s_dat_m;
    logic [79:0] s_dat_s;

    logic [4:0]  resp_ack = '0;
    logic [4:0]  stray    = '0;
    logic [15:0] slv_dat [5] = '{default: 16'h0};
    logic [15:0] base_dat [5] = '{16'hA000, 16'hBEEF, 16'hC0DE, 16'hD000, 16'hE000};
    int          lat [5] = '{1, 1, 1, 1, 1};
    int          due_q [5][$];
    logic [15:0] dq_q [5][$];
    int          tick = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign s_stall = '0;
    assign s_ack   = resp_ack | stray;
    assign s_dat_s = {slv_dat[4], slv_dat[3], slv_dat[2], slv_dat[1], slv_dat[0]};

    wb_intercon_pipe #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .wbm_cyc(cyc), .wbm_stb(stb), .wbm_we(we), .wbm_adr(adr), .wbm_dat_m(dat_m),
        .wbm_dat_s(dat_s), .wbm_ack(ack), .wbm_err(err), .wbm_stall(stall),
        .wbs_cyc(s_cyc), .wbs_stb(s_stb), .wbs_we(s_we), .wbs_adr(s_adr), .wbs_dat_m(s_dat_m),
        .wbs_dat_s(s_dat_s), .wbs_ack(s_ack), .wbs_stall(s_stall)
    );

    // Slave responders: ack lat[i] cycles after the accepting cycle, data = base + adr[3:0]
    logic [4:0]  hs_s, ack_s, live_s;
    logic [15:0] adr_s;
    always begin
        @(negedge clk);
        hs_s   = s_cyc & s_stb & ~s_stall;
        ack_s  = resp_ack;
        live_s = s_cyc;
        adr_s  = s_adr;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (!live_s[i]) begin
                due_q[i].delete();
                dq_q[i].delete();
            end else begin
                if (ack_s[i] && due_q[i].size() > 0) begin
                    void'(due_q[i].pop_front());
                    void'(dq_q[i].pop_front());
                end
                if (hs_s[i]) begin
                    due_q[i].push_back(tick + lat[i]);
                    dq_q[i].push_back(base_dat[i] + {12'h0, adr_s[3:0]});
                end
            end
        end
        tick++;
        for (int i = 0; i < 5; i++) begin
            resp_ack[i] = (due_q[i].size() > 0) && (due_q[i][0] <= tick);
            slv_dat[i]  = (dq_q[i].size() > 0) ? dq_q[i][0] : 16'h0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'h4000; dat_m = 16'h0;
        step();
        #1;
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall got=%0b exp=1", stall); end
        n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got=%0b exp=0", ack); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%0b exp=0", err); end
        n_chk++; if (s_stb !== 5'b0) begin n_fail++; $display("FAIL rst_stb got=%b exp=00000", s_stb); end
        n_chk++; if (s_cyc !== 5'b0) begin n_fail++; $display("FAIL rst_cyc got=%b exp=00000", s_cyc); end
        n_chk++; if (s_adr !== 16'h0) begin n_fail++; $display("FAIL rst_adr got=%h exp=0000", s_adr); end
        step();
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        step();
    endtask

    task automatic test_single_read(input string tag);
        step();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'h4000;
        #1;
        n_chk++; if (s_stb !== 5'b00010) begin n_fail++; $display("FAIL %s_stb got=%b exp=00010", tag, s_stb); end
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL %s_stall got=%0b exp=0", tag, stall); end
        n_chk++; if (s_adr !== 16'h4000) begin n_fail++; $display("FAIL %s_adr got=%h exp=4000", tag, s_adr); end
        n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL %s_ack0 got=%0b exp=0", tag, ack); end
        step();
        stb = 1'b0;
        #1;
        n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL %s_ack1 got=%0b exp=1", tag, ack); end
        n_chk++; if (dat_s !== 16'hBEEF) begin n_fail++; $display("FAIL %s_dat got=%h exp=beef", tag, dat_s); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL %s_err got=%0b exp=0", tag, err); end
        step();
        cyc = 1'b0;
        #1;
        n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL %s_ack2 got=%0b exp=0", tag, ack); end
        n_chk++; if (dat_s !== 16'h0) begin n_fail++; $display("FAIL %s_dat_idle got=%h exp=0000", tag, dat_s); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] ack_exp;
        logic [5:0]  stall_exp;
        logic [15:0] dexp;
        ack_exp   = 11'b010_1111_0000;
        stall_exp = 6'b010000;
        lat[0]    = 4;
        for (int k = 0; k <= 10; k++) begin
            step();
            cyc = 1'b1;
            stb = (k <= 5);
            adr = (k < 4) ? 16'(k) : 16'h0004;
            #1;
            if (k <= 5) begin
                n_chk++;
                if (stall !== stall_exp[k]) begin
                    n_fail++; $display("FAIL b2b_stall c%0d got=%0b exp=%0b", k, stall, stall_exp[k]);
                end
            end
            n_chk++;
            if (ack !== ack_exp[k]) begin
                n_fail++; $display("FAIL b2b_ack c%0d got=%0b exp=%0b", k, ack, ack_exp[k]);
            end
            if (ack_exp[k]) begin
                dexp = 16'hA000 + ((k < 8) ? 16'(k - 4) : 16'h0004);
                n_chk++;
                if (dat_s !== dexp) begin
                    n_fail++; $display("FAIL b2b_dat c%0d got=%h exp=%h", k, dat_s, dexp);
                end
            end
        end
        step();
        cyc = 1'b0; stb = 1'b0;
        lat[0] = 1;
    endtask

    task automatic test_serialise();
        step();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'h4000;
        #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ser_stall0 got=%0b exp=0", stall); end
        step();
        adr = 16'h5000; we = 1'b1; dat_m = 16'h1234;
        #1;
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ser_stall1 got=%0b exp=1", stall); end
        n_chk++; if (s_stb !== 5'b0) begin n_fail++; $display("FAIL ser_stb1 got=%b exp=00000", s_stb); end
        n_chk++; if (s_cyc !== 5'b00110) begin n_fail++; $display("FAIL ser_cyc1 got=%b exp=00110", s_cyc); end
        n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL ser_ack1 got=%0b exp=1", ack); end
        n_chk++; if (dat_s !== 16'hBEEF) begin n_fail++; $display("FAIL ser_dat1 got=%h exp=beef", dat_s); end
        step();
        #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ser_stall2 got=%0b exp=0", stall); end
        n_chk++; if (s_stb !== 5'b00100) begin n_fail++; $display("FAIL ser_stb2 got=%b exp=00100", s_stb); end
        n_chk++; if (s_we !== 1'b1) begin n_fail++; $display("FAIL ser_we got=%0b exp=1", s_we); end
        n_chk++; if (s_dat_m !== 16'h1234) begin n_fail++; $display("FAIL ser_datm got=%h exp=1234", s_dat_m); end
        step();
        stb = 1'b0; we = 1'b0;
        #1;
        n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL ser_ack3 got=%0b exp=1", ack); end
        n_chk++; if (dat_s !== 16'hC0DE) begin n_fail++; $display("FAIL ser_dat3 got=%h exp=c0de", dat_s); end
        step();
        cyc = 1'b0;
    endtask

    task automatic test_unmapped();
        step();
        cyc = 1'b1; stb = 1'b1; adr = 16'h9000;
        #1;
        n_chk++; if (s_stb !== 5'b0) begin n_fail++; $display("FAIL unm_stb got=%b exp=00000", s_stb); end
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL unm_stall got=%0b exp=0", stall); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL unm_err0 got=%0b exp=0", err); end
        step();
        stb = 1'b0;
        #1;
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL unm_err1 got=%0b exp=1", err); end
        n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL unm_ack got=%0b exp=0", ack); end
        step();
        #1;
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL unm_err2 got=%0b exp=0", err); end
        cyc = 1'b0;
    endtask

    task automatic test_timeout();
        lat[1] = 1000;
        step();
        cyc = 1'b1; stb = 1'b1; adr = 16'h4000;
        #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL to_stall0 got=%0b exp=0", stall); end
        for (int k = 1; k <= 16; k++) begin
            step();
            stb = 1'b0;
            #1;
            n_chk++;
            if (err !== (k == 16)) begin
                n_fail++; $display("FAIL to_err c%0d got=%0b exp=%0b", k, err, (k == 16));
            end
        end
        n_chk++; if (s_cyc !== 5'b00010) begin n_fail++; $display("FAIL to_cyc16 got=%b exp=00010", s_cyc); end
        step();
        #1;
        n_chk++; if (s_cyc !== 5'b0) begin n_fail++; $display("FAIL to_cyc17 got=%b exp=00000", s_cyc); end
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL to_stall17 got=%0b exp=1", stall); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_err17 got=%0b exp=0", err); end
        step();
        cyc = 1'b0; stb = 1'b1;
        #1;
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL to_stall18 got=%0b exp=1", stall); end
        step();
        #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL to_stall19 got=%0b exp=0", stall); end
        stb = 1'b0;
        lat[1] = 1;
    endtask

    task automatic test_reset_mid();
        lat[0] = 5;
        step();
        cyc = 1'b1; stb = 1'b1; adr = 16'h0000;
        step();
        adr = 16'h0001;
        #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rmid_stall got=%0b exp=0", stall); end
        step();
        rst = 1'b1; stb = 1'b0;
        #1;
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rmid_rst_stall got=%0b exp=1", stall); end
        n_chk++; if (s_cyc !== 5'b0) begin n_fail++; $display("FAIL rmid_rst_cyc got=%b exp=00000", s_cyc); end
        step();
        rst = 1'b0; cyc = 1'b0; stray = 5'b00001;
        #1;
        n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rmid_stray_ack got=%0b exp=0", ack); end
        n_chk++; if (dat_s !== 16'h0) begin n_fail++; $display("FAIL rmid_dat got=%h exp=0000", dat_s); end
        step();
        stray = 5'b0;
        lat[0] = 1;
        test_single_read("rmid_s1");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read("s1");
        test_back_to_back();
        test_serialise();
        test_unmapped();
        test_timeout();
        test_reset_mid();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
